f32_result_fifo: RTL

Downstream output stage of the binary32 ALU. Captures each result word and its 2-bit opcode tag from the ALU and classifies the value (zero, subnormal, normal, infinity, quiet/signalling NaN). It buffers results in a small FIFO with a valid/ready handshake toward the consumer, and keeps saturating NaN/infinity event counters for debug.

---
 rtl/f32_result_fifo.sv | 130 +++++++++++++
 1 files changed

// File: rtl/f32_result_fifo.sv
// Result FIFO for the binary32 ALU: buffers result/op-tag pairs behind a valid/ready handshake.
// Define F32_RES_CLASSIFY_EN to build the per-entry classifier and the NaN/inf event counters.
module f32_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_data,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [1:0]               out_op,
    output logic [2:0]               out_class,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     clr_cnt,
    output logic [CNT_W-1:0]         nan_cnt,
    output logic [CNT_W-1:0]         inf_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   data_mem [DEPTH];
    logic [1:0]    op_mem   [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data  = data_mem[rd_ptr];
    assign out_op    = op_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                op_mem[i]   <= '0;
            end
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= in_data;
                op_mem[wr_ptr]   <= in_op;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef F32_RES_CLASSIFY_EN
    logic [2:0] class_mem [DEPTH];
    logic [2:0] in_class;
    logic       in_is_nan;
    logic       in_is_inf;

    // Sign bit plays no part; exponent all-zeros / all-ones select the special classes.
    function automatic logic [2:0] classify(input logic [7:0] e, input logic [22:0] f);
        logic [2:0] c;
        case (e)
            8'h00:   c = (f == '0) ? 3'd0 : 3'd1;
            8'hFF:   begin
                if (f == '0)     c = 3'd3;
                else if (f[22])  c = 3'd4;
                else             c = 3'd5;
            end
            default: c = 3'd2;
        endcase
        return c;
    endfunction

    assign in_class  = classify(in_data[30:23], in_data[22:0]);
    assign in_is_nan = (in_class == 3'd4) || (in_class == 3'd5);
    assign in_is_inf = (in_class == 3'd3);
    assign out_class = class_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                class_mem[i] <= '0;
            end
        end else if (push) begin
            class_mem[wr_ptr] <= in_class;
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rstn) begin
            nan_cnt <= '0;
            inf_cnt <= '0;
        end else if (clr_cnt) begin
            nan_cnt <= '0;
            inf_cnt <= '0;
        end else if (push) begin
            if (in_is_nan && (nan_cnt != '1)) begin
                nan_cnt <= nan_cnt + CNT_W'(1);
            end
            if (in_is_inf && (inf_cnt != '1)) begin
                inf_cnt <= inf_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt;
    assign out_class      = 3'd7;
    assign nan_cnt        = '0;
    assign inf_cnt        = '0;
`endif

endmodule
